// File: rtl/serv_predecode_pkg.sv
// Shared opcode constants and the per-entry payload of the predecode FIFO.
package serv_predecode_pkg;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    typedef struct packed {
        logic [31:0] instr;
        logic        rd_op;
        logic        rd_nz;
        logic        two_stage;
        logic        mdu;
        logic        illegal;
    } entry_t;

endpackage

// File: rtl/serv_predecode_fifo_if.sv
// Fetch-side push port and decode-side pop port of the predecode FIFO.
interface serv_predecode_fifo_if #(
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic          i_valid;
    logic          o_ready;
    logic [31:0]   i_instr;
    logic          o_valid;
    logic          i_ready;
    logic [31:0]   o_instr;
    logic [4:0]    o_opcode;
    logic [2:0]    o_funct3;
    logic          o_rd_op;
    logic          o_rd_nz;
    logic          o_two_stage_op;
    logic          o_mdu_op;
    logic          o_illegal;
    logic [LW-1:0] o_level;

    modport master (
        output i_valid, i_instr, i_ready,
        input  o_ready, o_valid, o_instr, o_opcode, o_funct3, o_rd_op,
               o_rd_nz, o_two_stage_op, o_mdu_op, o_illegal, o_level
    );

    modport slave (
        input  i_valid, i_instr, i_ready,
        output o_ready, o_valid, o_instr, o_opcode, o_funct3, o_rd_op,
               o_rd_nz, o_two_stage_op, o_mdu_op, o_illegal, o_level
    );

endinterface

// File: rtl/serv_predecode.sv
// Combinational predecode of one instruction word into a FIFO entry.
module serv_predecode
    import serv_predecode_pkg::*;
#(
    parameter int unsigned MDU = 0
) (
    input  logic [31:0] instr_i,
    output entry_t      entry_o
);

    logic [4:0] op;
    logic [2:0] f3;
    logic       mdu;

    assign op  = instr_i[6:2];
    assign f3  = instr_i[14:12];
    assign mdu = (MDU != 0) & (op == OP_OP) & instr_i[25];

    always_comb begin
        entry_o           = '0;
        entry_o.instr     = instr_i;
        entry_o.mdu       = mdu;
        entry_o.two_stage = ~op[2]
                          | (f3[0] & ~f3[1] & ~op[0] & ~op[4])
                          | (f3[1] & ~f3[2] & ~op[0] & ~op[4])
                          | mdu;
        entry_o.rd_op     = op[2]
                          | (~op[2] & op[4] & op[0])
                          | (~op[2] & ~op[3] & ~op[0]);
        entry_o.rd_nz     = entry_o.rd_op & (instr_i[11:7] != 5'd0);
        entry_o.illegal   = (instr_i[1:0] != 2'b11);
    end

endmodule

// File: rtl/serv_predecode_fifo.sv
// Instruction buffer between fetch and decode; predecodes at write, pops one entry per cycle.
module serv_predecode_fifo
    import serv_predecode_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned MDU   = 0
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    serv_predecode_fifo_if.slave  bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    entry_t          mem_q [DEPTH];
    entry_t          wr_entry;
    entry_t          head;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            ready;
    logic            valid;
    logic            push;
    logic            pop;

    serv_predecode #(.MDU(MDU)) u_predecode (
        .instr_i (bus.i_instr),
        .entry_o (wr_entry)
    );

    // Ready depends only on the registered level, so full blocks a push even during a pop.
    assign ready = (level_q != LW'(DEPTH));
    assign valid = (level_q != '0);
    assign push  = bus.i_valid & ready;
    assign pop   = valid & bus.i_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is deliberately unreset; empty-state outputs are masked below.
    always_ff @(posedge clk) begin
        if (push && !i_flush) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head = valid ? mem_q[rd_ptr_q] : '0;

    assign bus.o_ready        = ready;
    assign bus.o_valid        = valid;
    assign bus.o_instr        = head.instr;
    assign bus.o_opcode       = head.instr[6:2];
    assign bus.o_funct3       = head.instr[14:12];
    assign bus.o_rd_op        = head.rd_op;
    assign bus.o_rd_nz        = head.rd_nz;
    assign bus.o_two_stage_op = head.two_stage;
    assign bus.o_mdu_op       = head.mdu;
    assign bus.o_illegal      = head.illegal;
    assign bus.o_level        = level_q;

endmodule

// File: tb/tb_serv_predecode_fifo.sv
// Drives a DEPTH=2/MDU=0 and a DEPTH=4/MDU=1 instance in lockstep against queue models.
module tb_serv_predecode_fifo;

    localparam int unsigned DA = 2;
    localparam int unsigned DB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        valid;
    logic        rdy;
    logic [31:0] instr;

    int checks = 0;
    int errors = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];

    serv_predecode_fifo_if #(.DEPTH(DA)) bus_a ();
    serv_predecode_fifo_if #(.DEPTH(DB)) bus_b ();

    assign bus_a.i_valid = valid;
    assign bus_a.i_instr = instr;
    assign bus_a.i_ready = rdy;
    assign bus_b.i_valid = valid;
    assign bus_b.i_instr = instr;
    assign bus_b.i_ready = rdy;

    serv_predecode_fifo #(.DEPTH(DA), .MDU(0)) dut_a (
        .clk     (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .bus     (bus_a)
    );

    serv_predecode_fifo #(.DEPTH(DB), .MDU(1)) dut_b (
        .clk     (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .bus     (bus_b)
    );

    always #5 clk = ~clk;

    // {rd_op, rd_nz, two_stage, mdu, illegal} from the field rules
    function automatic logic [4:0] flags(input logic [31:0] w, input bit mdu_en);
        logic [4:0] op;
        logic [2:0] f3;
        logic m, two, rdop, nz, ill;
        op   = w[6:2];
        f3   = w[14:12];
        m    = mdu_en && (op == 5'b01100) && w[25];
        two  = !op[2] || (f3 == 3'b001 || f3 == 3'b101 || f3 == 3'b010 || f3 == 3'b011)
                         && !op[0] && !op[4] || m;
        rdop = op[2] || (op[4] && op[0]) || (!op[3] && !op[0]);
        nz   = rdop && (w[11:7] != 5'd0);
        ill  = (w[1:0] != 2'b11);
        return {rdop, nz, two, m, ill};
    endfunction

    function automatic logic [49:0] exp_vec(input logic [31:0] hd, input int size,
                                            input int depth, input bit mdu_en);
        logic rdy_e;
        rdy_e = (size < depth);
        if (size == 0) return {1'b0, rdy_e, 3'd0, 45'd0};
        return {1'b1, rdy_e, 3'(size), hd, hd[6:2], hd[14:12], flags(hd, mdu_en)};
    endfunction

    function automatic logic [49:0] exp_a();
        return exp_vec(qa.size() > 0 ? qa[0] : 32'd0, qa.size(), DA, 1'b0);
    endfunction

    function automatic logic [49:0] exp_b();
        return exp_vec(qb.size() > 0 ? qb[0] : 32'd0, qb.size(), DB, 1'b1);
    endfunction

    function automatic logic [49:0] obs_a();
        return {bus_a.o_valid, bus_a.o_ready, 3'(bus_a.o_level), bus_a.o_instr,
                bus_a.o_opcode, bus_a.o_funct3, bus_a.o_rd_op, bus_a.o_rd_nz,
                bus_a.o_two_stage_op, bus_a.o_mdu_op, bus_a.o_illegal};
    endfunction

    function automatic logic [49:0] obs_b();
        return {bus_b.o_valid, bus_b.o_ready, 3'(bus_b.o_level), bus_b.o_instr,
                bus_b.o_opcode, bus_b.o_funct3, bus_b.o_rd_op, bus_b.o_rd_nz,
                bus_b.o_two_stage_op, bus_b.o_mdu_op, bus_b.o_illegal};
    endfunction

    // Advance both models with the current inputs, then clock and settle.
    task automatic step();
        bit pa, pb, oa, ob;
        if (!rst_n || flush) begin
            qa.delete();
            qb.delete();
        end else begin
            pa = valid && (qa.size() < DA);
            oa = rdy && (qa.size() > 0);
            pb = valid && (qb.size() < DB);
            ob = rdy && (qb.size() > 0);
            if (oa) void'(qa.pop_front());
            if (ob) void'(qb.pop_front());
            if (pa) qa.push_back(instr);
            if (pb) qb.push_back(instr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; valid = 1'b1; rdy = 1'b0; instr = 32'h00500093;
        step();
        step();
        rst_n = 1'b1; valid = 1'b0;
        checks++;
        if ({bus_a.o_valid, bus_a.o_ready, bus_a.o_level} !== {1'b0, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL reset_a: got v/r/l %b%b%0d want 0/1/0", bus_a.o_valid, bus_a.o_ready, bus_a.o_level);
        end
        checks++;
        if (obs_b() !== exp_b()) begin
            errors++;
            $display("FAIL reset_b: got %h want %h", obs_b(), exp_b());
        end
    endtask

    // Directed per-word field table: {word, fields_a, fields_b}, fields = {opcode,f3,rd_op,rd_nz,two,mdu,ill}
    task automatic test_fields();
        logic [31:0] words [6];
        logic [12:0] fa [6];
        logic [12:0] fb [6];
        words[0] = 32'h00500093; fa[0] = {5'b00100, 3'b000, 5'b11000}; fb[0] = fa[0];
        words[1] = 32'h0000A103; fa[1] = {5'b00000, 3'b010, 5'b11100}; fb[1] = fa[1];
        words[2] = 32'h00000013; fa[2] = {5'b00100, 3'b000, 5'b10000}; fb[2] = fa[2];
        words[3] = 32'h022081B3; fa[3] = {5'b01100, 3'b000, 5'b11000}; fb[3] = {5'b01100, 3'b000, 5'b11110};
        words[4] = 32'h00000000; fa[4] = {5'b00000, 3'b000, 5'b10101}; fb[4] = fa[4];
        words[5] = 32'h0020A023; fa[5] = {5'b01000, 3'b010, 5'b00100}; fb[5] = fa[5];
        for (int i = 0; i < 6; i++) begin
            valid = 1'b1; rdy = 1'b1; instr = words[i];
            step();
            valid = 1'b0;
            checks++;
            if ({bus_a.o_valid, bus_a.o_opcode, bus_a.o_funct3, bus_a.o_rd_op, bus_a.o_rd_nz,
                 bus_a.o_two_stage_op, bus_a.o_mdu_op, bus_a.o_illegal} !== {1'b1, fa[i]}) begin
                errors++;
                $display("FAIL fields_a[%0d]: got %b%b want 1%b", i, bus_a.o_valid,
                         {bus_a.o_opcode, bus_a.o_funct3, bus_a.o_rd_op, bus_a.o_rd_nz,
                          bus_a.o_two_stage_op, bus_a.o_mdu_op, bus_a.o_illegal}, fa[i]);
            end
            checks++;
            if ({bus_b.o_valid, bus_b.o_opcode, bus_b.o_funct3, bus_b.o_rd_op, bus_b.o_rd_nz,
                 bus_b.o_two_stage_op, bus_b.o_mdu_op, bus_b.o_illegal} !== {1'b1, fb[i]}) begin
                errors++;
                $display("FAIL fields_b[%0d]: got %b%b want 1%b", i, bus_b.o_valid,
                         {bus_b.o_opcode, bus_b.o_funct3, bus_b.o_rd_op, bus_b.o_rd_nz,
                          bus_b.o_two_stage_op, bus_b.o_mdu_op, bus_b.o_illegal}, fb[i]);
            end
            step();
            checks++;
            if ({bus_a.o_valid, bus_a.o_instr, bus_a.o_opcode, bus_a.o_rd_op, bus_a.o_two_stage_op,
                 bus_a.o_illegal} !== 41'd0) begin
                errors++;
                $display("FAIL empty_zero[%0d]: got v=%b instr=%h", i, bus_a.o_valid, bus_a.o_instr);
            end
        end
        rdy = 1'b0;
    endtask

    task automatic test_full();
        logic [31:0] w [3];
        for (int i = 0; i < 3; i++) w[i] = 32'h00000013 | (32'(i + 1) << 7);
        rdy = 1'b0; valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr = w[i];
            step();
        end
        valid = 1'b0;
        checks++;
        if ({bus_a.o_level, bus_a.o_ready, bus_a.o_instr} !== {2'd2, 1'b0, w[0]}) begin
            errors++;
            $display("FAIL full_a: got l=%0d r=%b head=%h want l=2 r=0 head=%h",
                     bus_a.o_level, bus_a.o_ready, bus_a.o_instr, w[0]);
        end
        checks++;
        if (bus_b.o_level !== 3'd3) begin
            errors++;
            $display("FAIL full_b: got level %0d want 3", bus_b.o_level);
        end
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs_a() !== exp_a()) begin
                errors++;
                $display("FAIL drain_a[%0d]: got %h want %h", i, obs_a(), exp_a());
            end
            checks++;
            if (obs_b() !== exp_b()) begin
                errors++;
                $display("FAIL drain_b[%0d]: got %h want %h", i, obs_b(), exp_b());
            end
        end
        for (int i = 0; i < 10; i++) begin
            valid = 1'b1; instr = $urandom; rdy = (i % 3) != 0;
            step();
            checks++;
            if (obs_a() !== exp_a()) begin
                errors++;
                $display("FAIL wrap_a[%0d]: got %h want %h", i, obs_a(), exp_a());
            end
        end
        valid = 1'b0; rdy = 1'b1;
        step(); step(); step(); step();
        rdy = 1'b0;
    endtask

    task automatic test_same_cycle();
        valid = 1'b1; rdy = 1'b0; instr = 32'h00100093;
        step();
        instr = 32'h00200113; rdy = 1'b1;
        step();
        valid = 1'b0; rdy = 1'b0;
        checks++;
        if ({bus_a.o_level, bus_a.o_instr} !== {2'd1, 32'h00200113}) begin
            errors++;
            $display("FAIL pushpop_a: got l=%0d head=%h want l=1 head=00200113", bus_a.o_level, bus_a.o_instr);
        end
        checks++;
        if (obs_b() !== exp_b()) begin
            errors++;
            $display("FAIL pushpop_b: got %h want %h", obs_b(), exp_b());
        end
        flush = 1'b1; valid = 1'b1; rdy = 1'b1; instr = 32'h00300193;
        step();
        flush = 1'b0; valid = 1'b0; rdy = 1'b0;
        checks++;
        if ({bus_a.o_level, bus_a.o_valid, bus_b.o_level, bus_b.o_valid} !== {2'd0, 1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL flush: got la=%0d lb=%0d va=%b vb=%b want 0", bus_a.o_level, bus_b.o_level,
                     bus_a.o_valid, bus_b.o_valid);
        end
    endtask

    task automatic test_reset_mid();
        valid = 1'b1; rdy = 1'b0; instr = 32'h00000000;
        step();
        instr = 32'h00400213;
        step();
        checks++;
        if ({bus_a.o_level, bus_a.o_illegal} !== {2'd2, 1'b1}) begin
            errors++;
            $display("FAIL illegal_head: got l=%0d ill=%b want l=2 ill=1", bus_a.o_level, bus_a.o_illegal);
        end
        rst_n = 1'b0; flush = 1'b1;
        step();
        rst_n = 1'b1; flush = 1'b0; valid = 1'b0;
        checks++;
        if ({bus_a.o_level, bus_a.o_valid, bus_a.o_ready} !== {2'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid: got l=%0d v=%b r=%b want 0/0/1", bus_a.o_level, bus_a.o_valid, bus_a.o_ready);
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [6];
        pool[0] = 32'h00500093; pool[1] = 32'h0000A103; pool[2] = 32'h022081B3;
        pool[3] = 32'h0020A023; pool[4] = 32'h00000013; pool[5] = 32'h02000033;
        for (int i = 0; i < 400; i++) begin
            valid = ($urandom_range(0, 3) != 0);
            rdy   = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 31) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            instr = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 5)] : $urandom;
            step();
            checks++;
            if (obs_a() !== exp_a()) begin
                errors++;
                $display("FAIL rand_a[%0d]: got %h want %h", i, obs_a(), exp_a());
            end
            checks++;
            if (obs_b() !== exp_b()) begin
                errors++;
                $display("FAIL rand_b[%0d]: got %h want %h", i, obs_b(), exp_b());
            end
        end
        rst_n = 1'b1; flush = 1'b0; valid = 1'b0; rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fields();
        test_full();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serv_predecode_fifo.md
Name: serv_predecode_fifo

Overview:
- Parametrised instruction buffer placed between the instruction bus response and the decode stage.
- Accepts fetched 32-bit instructions through a valid/ready handshake and predecodes a subset of control fields at write time.
- Stores each instruction with its predecoded fields in a DEPTH-entry FIFO. The decoder pops one entry at a time.
- Successor to the single-instruction latch in the decoder: adds queue depth, flush, occupancy, an illegal-encoding flag and a rd-nonzero qualifier.

Parameters:
- DEPTH, 2, number of entries; power of two, >= 2.
- MDU, 0, 1 enables M-extension predecode (o_mdu_op can assert).

Ports:
- clk  in  1  clock
- i_rst_n  in  1  reset; synchronous, active-low
- i_flush  in  1  discard all entries (branch/trap redirect)
- i_valid  in  1  i_instr holds a fetched instruction
- o_ready  out  1  FIFO can accept a push this cycle
- i_instr  in  32  fetched instruction word
- o_valid  out  1  head entry available
- i_ready  in  1  decoder consumes the head entry
- o_instr  out  32  head instruction word
- o_opcode  out  5  head instr[6:2]
- o_funct3  out  3  head instr[14:12]
- o_rd_op  out  1  instruction writes rd
- o_rd_nz  out  1  o_rd_op and rd field (instr[11:7]) != 0
- o_two_stage_op  out  1  instruction needs a second execution stage
- o_mdu_op  out  1  M-extension op
- o_illegal  out  1  instr[1:0] != 2'b11
- o_level  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (i_rst_n=0 at a clk edge): read pointer, write pointer and level go to 0; o_valid=0 and o_ready=1 from the next cycle.
- While o_valid=0, every head-data output (o_instr through o_illegal) is forced to 0. Storage RAM itself is not reset.
- Push occurs when i_valid & o_ready. Pop occurs when o_valid & i_ready.
- o_ready = (level != DEPTH). It depends only on registered state; there is no combinational path from i_ready to o_ready. A push into a full FIFO is impossible even if a pop happens in the same cycle.
- Latency: an entry pushed at edge N is visible on the outputs after edge N (not fall-through in the push cycle).
- Simultaneous push and pop: level is unchanged; both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally. Level is held in a separate counter.
- Flush: when i_flush=1, level and both pointers go to 0 at the edge. Any push or pop in the same cycle is ignored. Reset has priority over flush.
- Predecode is computed from i_instr at push time and stored per entry. With op=instr[6:2], f3=instr[14:12]:
  - mdu = MDU & (op==5'b01100) & instr[25]
  - two_stage = ~op[2] | (f3[0]&~f3[1]&~op[0]&~op[4]) | (f3[1]&~f3[2]&~op[0]&~op[4]) | mdu
  - rd_op = op[2] | (~op[2]&op[4]&op[0]) | (~op[2]&~op[3]&~op[0])
  - illegal = (instr[1:0] != 2'b11)
- Illegal entries are queued normally; the flag is informational only.

Decomposition:
- Package serv_predecode_pkg holds:
  - the opcode constants (OP_LOAD=5'b00000, OP_OPIMM=5'b00100, OP_OP=5'b01100, OP_BRANCH=5'b11000, OP_SYSTEM=5'b11100);
  - a packed entry typedef: instr[31:0], rd_op, rd_nz, two_stage, mdu, illegal.
- Sub-module serv_predecode: purely combinational, instr in, predecoded fields out. It is instantiated once at the FIFO write port.

Test Plan:
- Reset then push 0x00500093 (addi x1,x0,5), i_ready=1 -> next cycle o_valid=1, opcode=00100, funct3=000, rd_op=1, rd_nz=1, two_stage=0, illegal=0. After pop, o_valid=0 and all data outputs are 0.
- Push 0x0000A103 (lw x2,0(x1)) -> opcode=00000, funct3=010, two_stage=1, rd_op=1. Push 0x00000013 (nop) -> rd_op=1, rd_nz=0.
- Push 0x022081B3 (mul x3,x1,x2): with MDU=1 -> mdu=1, two_stage=1. With MDU=0 -> mdu=0, two_stage=0.
- DEPTH=2, i_ready=0, push three words -> o_level reaches 2, o_ready=0, the third word is not accepted. Set i_ready=1 -> entries pop in FIFO order; o_ready=1 after the first pop. Run 10 pushes/pops to check pointer wrap and order.
- With the FIFO at level 1, push and pop in the same cycle -> level stays 1 and the head becomes the new word. Flush asserted together with i_valid -> level=0 and the pushed word is dropped.
- Push 0x00000000 -> illegal=1. Reset mid-stream at level 2 -> next cycle level=0, o_valid=0, o_ready=1.
